// File: rtl/rvv_alu_seq.sv
// Self-sequencing multi-lane vector integer ALU: one start handshake processes
// vl elements lane-parallel, wide elements as LSB-first chunks with carry chaining.
module rvv_alu_seq #(
  parameter int VLEN     = 128,
  parameter int LANE_W   = 32,
  parameter int NB_LANES = 2
) (
  input  logic                    clk,
  input  logic                    resetn,
  input  logic                    start,
  output logic                    ready,
  output logic                    busy,
  output logic                    done,
  output logic                    illegal,
  input  logic [5:0]              opcode,
  input  logic [2:0]              op_type,
  input  logic [2:0]              vsew,
  input  logic [$clog2(VLEN/8):0] vl,
  input  logic                    vm,
  input  logic [VLEN/8-1:0]       v0_mask,
  input  logic [VLEN-1:0]         vs1_in,
  input  logic [VLEN-1:0]         vs2_in,
  input  logic [63:0]             scalar,
  input  logic [VLEN-1:0]         vd_old,
  output logic [VLEN-1:0]         vd_out
);
  localparam int NE = VLEN / 8;
  localparam int EW = $clog2(NE) + 1;

  localparam logic [5:0] OP_ADD  = 6'b000000;
  localparam logic [5:0] OP_SUB  = 6'b000010;
  localparam logic [5:0] OP_RSUB = 6'b000011;
  localparam logic [5:0] OP_MINU = 6'b000100;
  localparam logic [5:0] OP_MIN  = 6'b000101;
  localparam logic [5:0] OP_MAXU = 6'b000110;
  localparam logic [5:0] OP_MAX  = 6'b000111;
  localparam logic [5:0] OP_AND  = 6'b001001;
  localparam logic [5:0] OP_OR   = 6'b001010;
  localparam logic [5:0] OP_XOR  = 6'b001011;

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_RUN = 2'd1, S_DONE = 2'd2} state_t;
  typedef struct packed {logic cout; logic [63:0] elem;} lane_res_t;

  function automatic logic [63:0] sew_mask(input logic [1:0] sew);
    return 64'hFFFF_FFFF_FFFF_FFFF >> (7'd64 - (7'd8 << sew));
  endfunction

  function automatic logic [63:0] get_elem(input logic [VLEN-1:0] v, input int idx, input logic [1:0] sew);
    logic [VLEN-1:0] sh;
    sh = v >> (idx * (8 << sew));
    return sh[63:0] & sew_mask(sew);
  endfunction

  function automatic logic [VLEN-1:0] put_elem(input logic [VLEN-1:0] v, input int idx,
                                               input logic [1:0] sew, input logic [63:0] val);
    int              pos;
    logic [VLEN-1:0] m;
    pos = idx * (8 << sew);
    m   = VLEN'(sew_mask(sew)) << pos;
    return (v & ~m) | (VLEN'(val & sew_mask(sew)) << pos);
  endfunction

  // One chunk of one lane; min/max reuse the vs2-vs1 subtract and pick a whole source element.
  function automatic lane_res_t lane_step(input logic [5:0] op, input logic [1:0] sew, input logic [3:0] chunk,
                                          input logic cin, input logic [63:0] acc,
                                          input logic [63:0] e2, input logic [63:0] e1);
    int                sew_bits, eff_w;
    logic [LANE_W-1:0] wmask, a, b, x, y, res, xs, ys;
    logic [LANE_W:0]   sum, t_sign, t_cout;
    logic              sr, ovf, lt, ltu;
    lane_res_t         r;
    sew_bits = 8 << sew;
    eff_w    = (sew_bits < LANE_W) ? sew_bits : LANE_W;
    wmask    = {LANE_W{1'b1}} >> (LANE_W - eff_w);
    a        = LANE_W'(e2 >> (int'(chunk) * LANE_W)) & wmask;
    b        = LANE_W'(e1 >> (int'(chunk) * LANE_W)) & wmask;
    case (op)
      OP_RSUB: begin x = b; y = ~a; end
      OP_ADD:  begin x = a; y = b;  end
      default: begin x = a; y = ~b; end
    endcase
    y      = y & wmask;
    sum    = {1'b0, x} + {1'b0, y} + {{LANE_W{1'b0}}, cin};
    t_sign = sum >> (eff_w - 1);
    t_cout = sum >> eff_w;
    xs     = x >> (eff_w - 1);
    ys     = y >> (eff_w - 1);
    sr     = t_sign[0];
    ovf    = (xs[0] == ys[0]) && (sr != xs[0]);
    lt     = sr ^ ovf;
    ltu    = ~t_cout[0];
    case (op)
      OP_AND:  res = a & b;
      OP_OR:   res = a | b;
      OP_XOR:  res = a ^ b;
      default: res = sum[LANE_W-1:0] & wmask;
    endcase
    r.cout = t_cout[0];
    case (op)
      OP_MIN:  r.elem = lt  ? e2 : e1;
      OP_MINU: r.elem = ltu ? e2 : e1;
      OP_MAX:  r.elem = lt  ? e1 : e2;
      OP_MAXU: r.elem = ltu ? e1 : e2;
      default: r.elem = acc | (64'(res) << (int'(chunk) * LANE_W));
    endcase
    return r;
  endfunction

  state_t            state_r, state_nx;
  logic              ready_r, busy_r, done_r, illegal_r;
  logic [5:0]        op_r;
  logic [1:0]        sew_r;
  logic              vv_r, vm_r;
  logic [NE-1:0]     mask_r;
  logic [VLEN-1:0]   vs1_r, vs2_r, vd_r, vd_nx;
  logic [63:0]       scalar_r;
  logic [EW-1:0]     vl_r, last_group_r, group_r;
  logic [3:0]        chunk_r, nchunk_r;
  logic [NB_LANES-1:0] carry_r, carry_nx;
  logic [63:0]       acc_r [NB_LANES];
  logic [63:0]       acc_nx [NB_LANES];

  logic              onehot_s, op_ok_s, illegal_in_s, accept_s, chunk_last_s, run_last_s;
  logic [EW-1:0]     vlmax_s, vl_clamp_s, last_group_s;
  logic [6:0]        sew_bits_s;
  logic [3:0]        nchunk_s;
  int                elem_idx_s [NB_LANES];
  logic [NE-1:0]     msh_s [NB_LANES];
  lane_res_t         lane_s [NB_LANES];

  // Decode of the request presented at start: legality, clamped vl, loop bounds.
  always_comb begin
    onehot_s = (op_type == 3'b001) || (op_type == 3'b010) || (op_type == 3'b100);
    case (opcode)
      OP_ADD, OP_AND, OP_OR, OP_XOR:     op_ok_s = 1'b1;
      OP_SUB:                            op_ok_s = (op_type != 3'b100);
      OP_RSUB:                           op_ok_s = (op_type != 3'b001);
      OP_MINU, OP_MIN, OP_MAXU, OP_MAX:  op_ok_s = (op_type != 3'b100);
      default:                           op_ok_s = 1'b0;
    endcase
    illegal_in_s = vsew[2] || !onehot_s || !op_ok_s;
    vlmax_s      = EW'(NE >> vsew[1:0]);
    vl_clamp_s   = (vl > vlmax_s) ? vlmax_s : vl;
    last_group_s = (vl_clamp_s - EW'(1)) / EW'(NB_LANES);
    sew_bits_s   = 7'd8 << vsew[1:0];
    nchunk_s     = (int'(sew_bits_s) > LANE_W) ? 4'(int'(sew_bits_s) / LANE_W - 1) : 4'd0;
    accept_s     = start && (state_r == S_IDLE);
    chunk_last_s = (chunk_r == nchunk_r);
    run_last_s   = chunk_last_s && (group_r == last_group_r);
  end

  // Next-state logic.
  always_comb begin
    state_nx = state_r;
    case (state_r)
      S_IDLE: begin
        if (start) state_nx = (illegal_in_s || vl_clamp_s == '0) ? S_DONE : S_RUN;
        else       state_nx = S_IDLE;
      end
      S_RUN: begin
        if (run_last_s) state_nx = S_DONE;
        else            state_nx = S_RUN;
      end
      S_DONE:  state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  // State register with registered status outputs.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_r   <= S_IDLE;
      ready_r   <= 1'b1;
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
      illegal_r <= 1'b0;
    end else begin
      state_r <= state_nx;
      ready_r <= (state_nx == S_IDLE);
      busy_r  <= (state_nx == S_RUN);
      done_r  <= (state_nx == S_DONE);
      if (accept_s) illegal_r <= illegal_in_s;
    end
  end

  // Lane datapath and element commit into the destination image.
  always_comb begin
    vd_nx = vd_r;
    for (int k = 0; k < NB_LANES; k++) begin
      elem_idx_s[k] = int'(group_r) * NB_LANES + k;
      msh_s[k]      = mask_r >> elem_idx_s[k];
      lane_s[k]     = lane_step(op_r, sew_r, chunk_r,
                                (chunk_r == 4'd0) ? (op_r != OP_ADD) : carry_r[k], acc_r[k],
                                get_elem(vs2_r, elem_idx_s[k], sew_r),
                                vv_r ? get_elem(vs1_r, elem_idx_s[k], sew_r) : (scalar_r & sew_mask(sew_r)));
      carry_nx[k]   = lane_s[k].cout;
      acc_nx[k]     = chunk_last_s ? 64'd0 : lane_s[k].elem;
      vd_nx = ((state_r == S_RUN) && chunk_last_s && (elem_idx_s[k] < int'(vl_r)) && (vm_r || msh_s[k][0]))
              ? put_elem(vd_nx, elem_idx_s[k], sew_r, lane_s[k].elem) : vd_nx;
    end
  end

  // Operand latch at acceptance, then chunk/group sequencing while running.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      op_r <= 6'd0; sew_r <= 2'd0; vv_r <= 1'b0; vm_r <= 1'b0; mask_r <= '0;
      vs1_r <= '0; vs2_r <= '0; scalar_r <= 64'd0; vd_r <= '0;
      vl_r <= '0; last_group_r <= '0; group_r <= '0; chunk_r <= 4'd0; nchunk_r <= 4'd0;
      carry_r <= '0;
      for (int k = 0; k < NB_LANES; k++) acc_r[k] <= 64'd0;
    end else if (accept_s) begin
      op_r <= opcode; sew_r <= vsew[1:0]; vv_r <= (op_type == 3'b001); vm_r <= vm; mask_r <= v0_mask;
      vs1_r <= vs1_in; vs2_r <= vs2_in; scalar_r <= scalar; vd_r <= vd_old;
      vl_r <= vl_clamp_s; last_group_r <= last_group_s; group_r <= '0; chunk_r <= 4'd0; nchunk_r <= nchunk_s;
      carry_r <= '0;
      for (int k = 0; k < NB_LANES; k++) acc_r[k] <= 64'd0;
    end else if (state_r == S_RUN) begin
      vd_r    <= vd_nx;
      carry_r <= carry_nx;
      acc_r   <= acc_nx;
      if (chunk_last_s) begin
        chunk_r <= 4'd0;
        group_r <= group_r + EW'(1);
      end else begin
        chunk_r <= chunk_r + 4'd1;
      end
    end
  end

  assign ready   = ready_r;
  assign busy    = busy_r;
  assign done    = done_r;
  assign illegal = illegal_r;
  assign vd_out  = vd_r;
endmodule
